// File: rtl/router_input_buffer_if.sv
// Link bundle between neighbouring pipeline stages: a flit channel travelling
// downstream and a two-bit flow-control word travelling upstream.
interface router_input_buffer_if #(
  parameter int FLIT_WIDTH = 68
);
  logic [0:FLIT_WIDTH-1] channel;
  logic [0:1]            flow_ctrl;

  // The sender of flits drives the channel and receives credits.
  modport master (output channel, input flow_ctrl);
  // The receiver of flits samples the channel and returns credits.
  modport slave (input channel, output flow_ctrl);
endinterface

// File: rtl/router_input_buffer.sv
// Ingress buffer in front of router_slice: queues link flits in a small FIFO,
// forwards them under credit flow control, returns one credit upstream per
// forwarded flit and flags overflow, framing and credit protocol violations.
module router_input_buffer #(
  parameter int FLIT_WIDTH         = 68,
  parameter int DEPTH              = 4,
  parameter int DOWNSTREAM_CREDITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  router_input_buffer_if.slave    up,
  router_input_buffer_if.master   down,
  output logic                    ERROR,
  output logic [0:2]              ERR_STATUS,
  output logic [0:$clog2(DEPTH)]  FIFO_COUNT
);

  localparam int CW   = $clog2(DEPTH);
  localparam int CNTW = CW + 1;
  localparam int CRW  = $clog2(DOWNSTREAM_CREDITS + 1);

  localparam logic [CW-1:0]   PTR_ONE     = CW'(1);
  localparam logic [CNTW-1:0] COUNT_ONE   = CNTW'(1);
  localparam logic [CNTW-1:0] COUNT_FULL  = CNTW'(DEPTH);
  localparam logic [CRW-1:0]  CRED_ONE    = CRW'(1);
  localparam logic [CRW-1:0]  CRED_MAX    = CRW'(DOWNSTREAM_CREDITS);

  typedef enum logic {IDLE, PKT} frame_state_t;

  logic [0:FLIT_WIDTH-1] mem [DEPTH];
  logic [CW-1:0]         rd_ptr;
  logic [CW-1:0]         wr_ptr;
  logic [CNTW-1:0]       count_q;
  logic [CRW-1:0]        credits_q;
  frame_state_t          state_q;
  frame_state_t          state_next;
  logic [0:FLIT_WIDTH-1] out_q;
  logic                  credit_ret_q;
  logic [0:2]            err_q;
  logic                  error_q;

  logic                  pop;
  logic                  push;
  logic                  overflow;
  logic                  cred_in;
  logic                  cred_sat;
  logic                  frame_err;
  logic [0:2]            err_set;
  logic [0:FLIT_WIDTH-1] head_flit;
  logic                  unused_flow_bit;

  assign unused_flow_bit = down.flow_ctrl[1];

  // Decide this cycle's pop/push, credit saturation and framing transition.
  always_comb begin
    pop        = (count_q != '0) && (credits_q != '0);
    push       = up.channel[0] && ((count_q != COUNT_FULL) || pop);
    overflow   = up.channel[0] && !push;
    cred_in    = down.flow_ctrl[0];
    cred_sat   = cred_in && !pop && (credits_q == CRED_MAX);
    head_flit  = mem[rd_ptr];
    head_flit[0] = 1'b1;
    state_next = state_q;
    frame_err  = 1'b0;
    if (push) begin
      case (state_q)
        IDLE: begin
          if (!up.channel[1])      frame_err  = 1'b1;
          else if (!up.channel[2]) state_next = PKT;
        end
        PKT: begin
          if (up.channel[1])       frame_err  = 1'b1;
          else if (up.channel[2])  state_next = IDLE;
        end
      endcase
    end
    err_set = {overflow, frame_err, cred_sat};
  end

  // Registered outputs, FIFO bookkeeping, credit counter and framing FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q        <= '0;
      credit_ret_q <= 1'b0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count_q      <= '0;
      credits_q    <= CRED_MAX;
      state_q      <= IDLE;
      err_q        <= '0;
      error_q      <= 1'b0;
    end else begin
      out_q        <= pop ? head_flit : '0;
      credit_ret_q <= pop;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count_q <= count_q + COUNT_ONE;
        2'b01:   count_q <= count_q - COUNT_ONE;
        default: count_q <= count_q;
      endcase
      if (pop && !cred_in)
        credits_q <= credits_q - CRED_ONE;
      else if (cred_in && !pop && !cred_sat)
        credits_q <= credits_q + CRED_ONE;
      state_q <= state_next;
      err_q   <= err_q | err_set;
      error_q <= |(err_q | err_set);
    end
  end

  // FIFO storage; contents need no reset because the pointers are cleared.
  always_ff @(posedge clk) begin
    if (!reset && push) mem[wr_ptr] <= up.channel;
  end

  assign down.channel = out_q;
  assign up.flow_ctrl = {credit_ret_q, 1'b0};
  assign ERROR        = error_q;
  assign ERR_STATUS   = err_q;
  assign FIFO_COUNT   = count_q;

endmodule

// File: tb/tb_router_input_buffer.sv
// Self-checking bench for router_input_buffer: a table of per-cycle vectors
// with expected outputs, a flit scoreboard, and a hand-written reset sequence.
module tb_router_input_buffer;

  localparam int FW = 68;

  typedef struct {
    logic        rst;
    logic        vld;
    logic        head;
    logic        tail;
    logic [64:0] payload;
    logic        ret;
    logic        exp_out;
    logic [2:0]  exp_count;
    logic [0:2]  exp_err;
    logic        drop;
  } vec_t;

  logic          clk;
  logic          reset;
  logic          error;
  logic [0:2]    err_status;
  logic [0:2]    fifo_count;

  int            n_compared;
  int            n_mismatch;
  int            out_pulses;
  logic [0:FW-1] sb [$];
  vec_t          vecs [$];

  router_input_buffer_if #(.FLIT_WIDTH(FW)) up_if ();
  router_input_buffer_if #(.FLIT_WIDTH(FW)) dn_if ();

  router_input_buffer #(
    .FLIT_WIDTH(FW),
    .DEPTH(4),
    .DOWNSTREAM_CREDITS(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .up(up_if),
    .down(dn_if),
    .ERROR(error),
    .ERR_STATUS(err_status),
    .FIFO_COUNT(fifo_count)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic rst, input logic vld, input logic head,
                              input logic tail, input logic [64:0] payload,
                              input logic ret, input logic exp_out, input int cnt,
                              input logic [0:2] err, input logic drop);
    vec_t v;
    v.rst = rst; v.vld = vld; v.head = head; v.tail = tail;
    v.payload = payload; v.ret = ret; v.exp_out = exp_out;
    v.exp_count = 3'(cnt); v.exp_err = err; v.drop = drop;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [71:0] act,
                              input logic [71:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then run the flit scoreboard after the edge.
  task automatic apply_stimulus(input vec_t v);
    logic [0:FW-1] flit;
    flit = {1'b1, v.head, v.tail, v.payload};
    @(negedge clk);
    reset           = v.rst;
    up_if.channel   = v.vld ? flit : '0;
    dn_if.flow_ctrl = {v.ret, 1'b0};
    @(posedge clk);
    #1;
    if (dn_if.channel[0]) begin
      out_pulses++;
      if (sb.size() == 0) begin
        n_compared++;
        n_mismatch++;
        $display("[TB] FAIL sb_underflow: got %0h expected no flit", dn_if.channel);
      end else begin
        check_output("sb_flit", 72'(dn_if.channel), 72'(sb.pop_front()));
      end
    end
    if (v.rst) sb.delete();
    else if (v.vld && !v.drop) sb.push_back(flit);
  endtask

  task automatic step(input logic rst, input logic vld, input logic head,
                      input logic tail, input logic [64:0] payload, input logic ret);
    apply_stimulus(mk(rst, vld, head, tail, payload, ret, 1'b0, 0, 3'b000, 1'b0));
  endtask

  task automatic check_vector(input int i, input vec_t v);
    check_output($sformatf("v%0d_out_valid", i), 72'(dn_if.channel[0]), 72'(v.exp_out));
    if (!v.exp_out)
      check_output($sformatf("v%0d_chan_idle", i), 72'(dn_if.channel), 72'(0));
    check_output($sformatf("v%0d_flow_out", i), 72'(up_if.flow_ctrl), 72'({v.exp_out, 1'b0}));
    check_output($sformatf("v%0d_count", i), 72'(fifo_count), 72'(v.exp_count));
    check_output($sformatf("v%0d_err_status", i), 72'(err_status), 72'(v.exp_err));
    check_output($sformatf("v%0d_error", i), 72'(error), 72'(|v.exp_err));
  endtask

  initial begin
    bit done;
    n_compared      = 0;
    n_mismatch      = 0;
    out_pulses      = 0;
    reset           = 1'b1;
    up_if.channel   = '0;
    dn_if.flow_ctrl = '0;

    // rst vld hd tl payload ret | out cnt err drop
    vecs.push_back(mk(1,0,0,0,65'h0,0, 0,0,3'b000,0));
    vecs.push_back(mk(1,0,0,0,65'h0,0, 0,0,3'b000,0));
    // single-flit packet, one cycle latency, one credit used then returned
    vecs.push_back(mk(0,1,1,1,65'h1_2345_6789_ABCD_EF01,0, 0,1,3'b000,0));
    vecs.push_back(mk(0,0,0,0,65'h0,0, 1,0,3'b000,0));
    vecs.push_back(mk(0,0,0,0,65'h0,0, 0,0,3'b000,0));
    vecs.push_back(mk(0,0,0,0,65'h0,1, 0,0,3'b000,0));
    // six-flit packet against four credits
    vecs.push_back(mk(0,1,1,0,65'h10,0, 0,1,3'b000,0));
    vecs.push_back(mk(0,1,0,0,65'h11,0, 1,1,3'b000,0));
    vecs.push_back(mk(0,1,0,0,65'h12,0, 1,1,3'b000,0));
    vecs.push_back(mk(0,1,0,0,65'h13,0, 1,1,3'b000,0));
    vecs.push_back(mk(0,1,0,0,65'h14,0, 1,1,3'b000,0));
    vecs.push_back(mk(0,1,0,1,65'h15,0, 0,2,3'b000,0));
    vecs.push_back(mk(0,0,0,0,65'h0,0, 0,2,3'b000,0));
    vecs.push_back(mk(0,0,0,0,65'h0,1, 0,2,3'b000,0));
    vecs.push_back(mk(0,0,0,0,65'h0,1, 1,1,3'b000,0));
    vecs.push_back(mk(0,0,0,0,65'h0,0, 1,0,3'b000,0));
    vecs.push_back(mk(0,0,0,0,65'h0,0, 0,0,3'b000,0));
    // zero credits: fill the FIFO, fifth flit overflows
    vecs.push_back(mk(0,1,1,0,65'h20,0, 0,1,3'b000,0));
    vecs.push_back(mk(0,1,0,0,65'h21,0, 0,2,3'b000,0));
    vecs.push_back(mk(0,1,0,0,65'h22,0, 0,3,3'b000,0));
    vecs.push_back(mk(0,1,0,0,65'h23,0, 0,4,3'b000,0));
    vecs.push_back(mk(0,1,0,1,65'h24,0, 0,4,3'b100,1));
    vecs.push_back(mk(0,0,0,0,65'h0,1, 0,4,3'b100,0));
    vecs.push_back(mk(0,0,0,0,65'h0,1, 1,3,3'b100,0));
    vecs.push_back(mk(0,0,0,0,65'h0,1, 1,2,3'b100,0));
    vecs.push_back(mk(0,0,0,0,65'h0,1, 1,1,3'b100,0));
    vecs.push_back(mk(0,0,0,0,65'h0,1, 1,0,3'b100,0));
    vecs.push_back(mk(0,0,0,0,65'h0,0, 0,0,3'b100,0));
    // refill credits to the maximum, then one return too many
    vecs.push_back(mk(0,0,0,0,65'h0,1, 0,0,3'b100,0));
    vecs.push_back(mk(0,0,0,0,65'h0,1, 0,0,3'b100,0));
    vecs.push_back(mk(0,0,0,0,65'h0,1, 0,0,3'b100,0));
    vecs.push_back(mk(0,0,0,0,65'h0,1, 0,0,3'b101,0));
    vecs.push_back(mk(0,0,0,0,65'h0,0, 0,0,3'b101,0));
    vecs.push_back(mk(1,0,0,0,65'h0,0, 0,0,3'b000,0));
    // body flit with no open packet is flagged yet forwarded
    vecs.push_back(mk(0,1,0,0,65'h30,0, 0,1,3'b010,0));
    vecs.push_back(mk(0,0,0,0,65'h0,0, 1,0,3'b010,0));
    vecs.push_back(mk(1,0,0,0,65'h0,0, 0,0,3'b000,0));
    // head flit following an open head flit
    vecs.push_back(mk(0,1,1,0,65'h31,0, 0,1,3'b000,0));
    vecs.push_back(mk(0,1,1,0,65'h32,0, 1,1,3'b010,0));
    vecs.push_back(mk(0,0,0,0,65'h0,0, 1,0,3'b010,0));

    $display("[TB] applying %0d table vectors", vecs.size());
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i]);
      check_vector(i, vecs[i]);
    end

    // Reset in the middle of a packet with three flits queued and no credits.
    step(1,0,0,0,65'h0,0);
    for (int i = 0; i < 4; i++) step(0,1,1,1,65'h40 + 65'(i),0);
    step(0,1,1,0,65'h44,0);
    step(0,1,0,0,65'h45,0);
    step(0,1,0,0,65'h46,0);
    check_output("mid_count", 72'(fifo_count), 72'(3));
    step(1,1,0,0,65'h47,0);
    check_output("rst_chan", 72'(dn_if.channel), 72'(0));
    check_output("rst_flow", 72'(up_if.flow_ctrl), 72'(0));
    check_output("rst_count", 72'(fifo_count), 72'(0));
    check_output("rst_err", 72'(err_status), 72'(0));
    check_output("rst_error", 72'(error), 72'(0));
    out_pulses = 0;
    step(0,1,0,0,65'h48,0);
    check_output("rst_fsm_idle", 72'(err_status), 72'(3'b010));
    for (int i = 0; i < 4; i++) step(0,1,0,0,65'h49 + 65'(i),0);
    for (int i = 0; i < 6; i++) step(0,0,0,0,65'h0,0);
    check_output("rst_credits", 72'(out_pulses), 72'(4));
    check_output("rst_stall_count", 72'(fifo_count), 72'(1));
    step(0,0,0,0,65'h0,1);
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      step(0,0,0,0,65'h0,0);
      if (fifo_count == 0) done = 1'b1;
    end
    check_output("drain_done", 72'(done), 72'(1));
    check_output("drain_pulses", 72'(out_pulses), 72'(5));
    check_output("sb_empty", 72'(sb.size()), 72'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
